// File: rtl/drive_sequencer_if.sv
// Signal bundle between the drive sequencer and its environment
// (user-input/debounce logic on the request side, speed unit on the pulse side).
//   go, target_speed, rev_req, estop : drive requests into the sequencer
//   speed_q                          : speed feedback from the speed unit
//   inc, dec                         : single-cycle step pulses to the speed unit
//   dir_fwd                          : committed direction (1 = forward)
//   at_speed, busy, state            : status / debug
interface drive_sequencer_if;
  logic       go;
  logic [3:0] target_speed;
  logic       rev_req;
  logic       estop;
  logic [3:0] speed_q;
  logic       inc;
  logic       dec;
  logic       dir_fwd;
  logic       at_speed;
  logic       busy;
  logic [2:0] state;

  // The sequencer side.
  modport master (
    input  go, target_speed, rev_req, estop, speed_q,
    output inc, dec, dir_fwd, at_speed, busy, state
  );

  // The environment side (requesters plus speed unit).
  modport slave (
    output go, target_speed, rev_req, estop, speed_q,
    input  inc, dec, dir_fwd, at_speed, busy, state
  );
endinterface

// File: rtl/drive_sequencer.sv
// Drive sequencer: turns a target speed, direction request, go enable and
// emergency stop into registered inc/dec step pulses for a 4-bit speed unit,
// and owns the committed direction bit. Direction only flips at standstill
// after a dwell period.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - drive_sequencer_if.master (requests, speed feedback, pulses, status)
module drive_sequencer #(
  parameter int unsigned STEP_DIV = 4,  // cycles per speed step, >= 2
  parameter int unsigned DWELL    = 8   // standstill cycles before a flip, >= 1
) (
  input  logic               clk,
  input  logic               reset,
  drive_sequencer_if.master  bus
);

  localparam int PW = $clog2(STEP_DIV);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCEL     = 3'd1,
    CRUISE    = 3'd2,
    DECEL     = 3'd3,
    STOP_WAIT = 3'd4,
    FLIP      = 3'd5,
    ESTOP     = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            inc_q, inc_d;
  logic            dec_q, dec_d;
  logic            dir_q, dir_d;

  logic            tick;
  logic            mism;
  logic [3:0]      tgt;
  logic [4:0]      proj_spd;

  // Free-running step prescaler.
  assign tick    = (presc_q == PW'(STEP_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Requested direction disagrees with the committed one.
  assign mism = (bus.rev_req == dir_q);
  assign tgt  = (!bus.go || mism) ? 4'd0 : bus.target_speed;

  // Speed once the pulse currently on the wire has landed. Pulses are
  // registered, so speed_q lags a decision by two edges; deciding on the
  // projected value stops back-to-back ESTOP pulses from overshooting zero.
  assign proj_spd = {1'b0, bus.speed_q} + {4'b0, inc_q} - {4'b0, dec_q};

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    dwell_d = '0;
    dir_d   = dir_q;

    unique case (state_q)
      IDLE: begin
        if (mism && bus.speed_q == 4'd0)  state_d = STOP_WAIT;
        else if (tgt > bus.speed_q)       state_d = ACCEL;
        else if (tgt < bus.speed_q)       state_d = DECEL;
      end

      ACCEL: begin
        inc_d = tick && (proj_spd < {1'b0, tgt});
        if (bus.speed_q == tgt)     state_d = CRUISE;
        else if (tgt < bus.speed_q) state_d = DECEL;
      end

      DECEL: begin
        dec_d = tick && (proj_spd > {1'b0, tgt});
        if (bus.speed_q == tgt) begin
          if (bus.speed_q == 4'd0 && mism) state_d = STOP_WAIT;
          else if (tgt == 4'd0)            state_d = IDLE;
          else                             state_d = CRUISE;
        end else if (tgt > bus.speed_q) begin
          state_d = ACCEL;
        end
      end

      CRUISE: begin
        if (tgt > bus.speed_q)                            state_d = ACCEL;
        else if (tgt < bus.speed_q)                       state_d = DECEL;
        else if (tgt == 4'd0 && bus.speed_q == 4'd0)      state_d = IDLE;
      end

      STOP_WAIT: begin
        if (!mism)                            state_d = IDLE;
        else if (dwell_q == DW'(DWELL - 1))   state_d = FLIP;
        else                                  dwell_d = dwell_q + 1'b1;
      end

      FLIP: begin
        state_d = IDLE;
        dir_d   = ~dir_q;
      end

      ESTOP: begin
        // Prescaler ignored: one step per cycle until standstill.
        dec_d = (proj_spd != 5'd0);
        if (!bus.estop && !bus.go && bus.speed_q == 4'd0) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Emergency stop overrides every other decision; direction is frozen.
    if (bus.estop) begin
      state_d = ESTOP;
      dir_d   = dir_q;
      inc_d   = 1'b0;
      dwell_d = '0;
      if (state_q != ESTOP) dec_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      dwell_q <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.inc      = inc_q;
  assign bus.dec      = dec_q;
  assign bus.dir_fwd  = dir_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.state    = state_q;
  // Held low while reset is asserted so the status reads "not at speed".
  assign bus.at_speed = reset && (state_q == IDLE || state_q == CRUISE) &&
                        (bus.speed_q == tgt);

endmodule

// File: tb/tb_drive_sequencer.sv
module tb_drive_sequencer;
  localparam int STEP_DIV = 4;
  localparam int DWELL    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  drive_sequencer_if sif();

  drive_sequencer #(.STEP_DIV(STEP_DIV), .DWELL(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  // Speed unit model: steps on the edge after a pulse; hold mode pins speed_q.
  logic [3:0] spd_q;
  logic       hold;
  logic [3:0] hold_val;
  always @(posedge clk or negedge reset) begin
    if (!reset)                             spd_q <= 4'd0;
    else if (sif.inc && spd_q != 4'd15)     spd_q <= spd_q + 4'd1;
    else if (sif.dec && spd_q != 4'd0)      spd_q <= spd_q - 4'd1;
  end
  assign sif.speed_q = hold ? hold_val : spd_q;

  int tests  = 0;
  int failed = 0;
  int inc_cnt = 0;
  int dec_cnt = 0;
  int ramp_id = 0;
  logic exp_dir;
  logic dir_known;
  logic estop_phase;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle checker: rule-level properties of the outputs.
  task automatic compare_loop();
    int n = 0;
    int last_n = 0;
    int last_type = 0;
    int last_ramp = -1;
    int typ;
    int exp_tgt;
    bit exp_at;
    forever begin
      @(posedge clk);
      if (!reset) n = 0; else n++;
      #1;
      if (reset) begin
        if (sif.inc) inc_cnt++;
        if (sif.dec) dec_cnt++;
        check("inc_dec_exclusive", int'(sif.inc && sif.dec), 0);
        check("no_inc_at_15", int'(sif.inc && sif.speed_q == 4'd15), 0);
        check("no_dec_at_0", int'(sif.dec && sif.speed_q == 4'd0), 0);
        check("busy_vs_state", int'(sif.busy), int'(sif.state != 3'd0));
        if (dir_known) begin
          check("dir_fwd", int'(sif.dir_fwd), int'(exp_dir));
          exp_tgt = (!sif.go || (sif.rev_req == exp_dir)) ? 0 : int'(sif.target_speed);
          exp_at  = (sif.state == 3'd0 || sif.state == 3'd2) && (int'(sif.speed_q) == exp_tgt);
          check("at_speed", int'(sif.at_speed), int'(exp_at));
        end
        if ((sif.inc || sif.dec) && !estop_phase) begin
          // A ramp pulse follows a prescaler wrap: every STEP_DIV edges since reset.
          check("pulse_phase", n % STEP_DIV, 0);
          typ = sif.inc ? 1 : 2;
          if (ramp_id != last_ramp) last_type = 0;
          if (typ == last_type) check("pulse_spacing", n - last_n, STEP_DIV);
          last_type = typ;
          last_n    = n;
          last_ramp = ramp_id;
        end
      end
    end
  endtask

  // Poll every falling edge until state (and optionally speed) match.
  task automatic wait_for(input string name, input int st, input int sp,
                          input bit use_sp, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(sif.state) == st && (!use_sp || int'(sif.speed_q) == sp)) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int b;
    int cnt;
    reset = 1'b0;
    sif.go = 1'b0;
    sif.target_speed = 4'd0;
    sif.rev_req = 1'b0;
    sif.estop = 1'b0;
    hold = 1'b0;
    hold_val = 4'd0;
    exp_dir = 1'b1;
    dir_known = 1'b0;
    estop_phase = 1'b0;
    fork
      compare_loop();
    join_none

    // 1. Reset state.
    repeat (3) @(negedge clk);
    check("rst_inc", int'(sif.inc), 0);
    check("rst_dec", int'(sif.dec), 0);
    check("rst_dir", int'(sif.dir_fwd), 1);
    check("rst_state", int'(sif.state), 0);
    check("rst_busy", int'(sif.busy), 0);
    check("rst_at_speed", int'(sif.at_speed), 0);
    reset = 1'b1;
    dir_known = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_state", int'(sif.state), 0);
    check("idle_at_speed", int'(sif.at_speed), 1);

    // 2. Ramp forward to 5.
    ramp_id++;
    b = inc_cnt;
    sif.go = 1'b1;
    sif.target_speed = 4'd5;
    wait_for("ramp5", 2, 5, 1'b1, 100);
    check("ramp5_incs", inc_cnt - b, 5);
    check("ramp5_at_speed", int'(sif.at_speed), 1);

    // 3. Reverse request: decelerate, dwell, flip, re-accelerate.
    ramp_id++;
    b = dec_cnt;
    sif.rev_req = 1'b1;
    wait_for("stop_wait", 4, 0, 1'b0, 100);
    check("rev_decs", dec_cnt - b, 5);
    check("rev_speed0", int'(sif.speed_q), 0);
    cnt = 0;
    while (sif.state == 3'd4 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("dwell_cycles", cnt, DWELL);
    check("flip_state", int'(sif.state), 5);
    check("flip_dir_before", int'(sif.dir_fwd), 1);
    dir_known = 1'b0;
    @(negedge clk);
    check("flip_dir_after", int'(sif.dir_fwd), 0);
    check("after_flip_state", int'(sif.state), 0);
    exp_dir = 1'b0;
    dir_known = 1'b1;
    b = inc_cnt;
    wait_for("rev_ramp5", 2, 5, 1'b1, 100);
    check("rev_incs", inc_cnt - b, 5);

    // 4. Emergency stop from speed 7.
    ramp_id++;
    sif.target_speed = 4'd7;
    wait_for("ramp7", 2, 7, 1'b1, 100);
    estop_phase = 1'b1;
    sif.estop = 1'b1;
    wait_for("estop_enter", 6, 0, 1'b0, 5);
    cnt = 0;
    while (!sif.dec && cnt < 3) begin
      cnt++;
      @(negedge clk);
    end
    cnt = 0;
    while (sif.dec && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("estop_dec_run", cnt, 7);
    check("estop_speed0", int'(sif.speed_q), 0);
    check("estop_state", int'(sif.state), 6);
    sif.estop = 1'b0;
    repeat (4) @(negedge clk);
    check("estop_hold_go", int'(sif.state), 6);
    sif.go = 1'b0;
    @(negedge clk);
    check("estop_exit", int'(sif.state), 0);
    estop_phase = 1'b0;

    // 5. Reset in the middle of an accel pulse at speed 3 of 10.
    ramp_id++;
    sif.go = 1'b1;
    sif.target_speed = 4'd10;
    cnt = 0;
    while (!(sif.inc && sif.speed_q == 4'd3) && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("mid_accel_found", int'(cnt < 200), 1);
    reset = 1'b0;
    dir_known = 1'b0;
    #1;
    check("async_inc", int'(sif.inc), 0);
    check("async_state", int'(sif.state), 0);
    check("async_dir", int'(sif.dir_fwd), 1);
    sif.rev_req = 1'b0;
    exp_dir = 1'b1;
    repeat (2) @(negedge clk);
    ramp_id++;
    reset = 1'b1;
    dir_known = 1'b1;
    @(posedge clk);
    #1;
    check("release_inc", int'(sif.inc), 0);
    check("release_dec", int'(sif.dec), 0);
    wait_for("ramp10", 2, 10, 1'b1, 200);

    // 6. Boundaries: held at 15 with target 15, then 0 with target 0.
    b = inc_cnt;
    hold = 1'b1;
    hold_val = 4'd15;
    sif.target_speed = 4'd15;
    repeat (12) @(negedge clk);
    check("top_no_inc", inc_cnt - b, 0);
    check("top_state", int'(sif.state), 2);
    check("top_at_speed", int'(sif.at_speed), 1);
    b = dec_cnt;
    hold_val = 4'd0;
    sif.target_speed = 4'd0;
    repeat (12) @(negedge clk);
    check("bottom_no_dec", dec_cnt - b, 0);
    check("bottom_state", int'(sif.state), 0);
    check("bottom_at_speed", int'(sif.at_speed), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
Controller that sequences the 4-bit car speed datapath. Converts a target speed, a direction request, a go enable and an emergency stop into single-cycle increment/decrement step pulses and a committed direction bit. Direction reversal only happens at standstill. Sits between the user-input/debounce logic and the speed unit, and closes the loop on the speed unit's `speed_q` feedback.

Parameters:
- STEP_DIV, 4, clock cycles per speed step in normal ramping; legal values >= 2.
- DWELL, 8, cycles held at standstill before a direction flip; legal values >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  1 = drive toward target_speed; 0 = coast down to 0.
- target_speed  input  4  requested speed magnitude, 0..15.
- rev_req  input  1  requested direction; 1 = reverse, 0 = forward.
- estop  input  1  emergency stop, level sensitive.
- speed_q  input  4  current speed from the speed unit; updates on the edge after an inc/dec pulse.
- inc  output  1  one-cycle pulse: speed unit adds 1.
- dec  output  1  one-cycle pulse: speed unit subtracts 1.
- dir_fwd  output  1  committed direction to the speed unit; 1 = forward, 0 = reverse.
- at_speed  output  1  1 when speed_q equals the effective target and the FSM is in IDLE or CRUISE.
- busy  output  1  1 in any state other than IDLE.
- state  output  3  FSM encoding for debug.

Behaviour:
- **Reset (reset=0, async):**
  - Outputs: inc=0, dec=0, dir_fwd=1, at_speed=0, busy=0, state=IDLE.
  - Internal: prescaler=0, dwell counter=0.
  - Reset applied mid-ramp aborts immediately; no pulse is emitted in the cycle reset releases.
- **Prescaler:** counts 0..STEP_DIV-1 continuously; tick=1 when count==STEP_DIV-1.
- **Effective target (tgt):**
  - 0 if go=0, or if rev_req differs from the committed direction (!dir_fwd).
  - target_speed otherwise.
- **States (encoding):** IDLE=0, ACCEL=1, CRUISE=2, DECEL=3, STOP_WAIT=4, FLIP=5, ESTOP=6.
- **IDLE:**
  - If a direction mismatch exists and speed_q==0 → STOP_WAIT.
  - Else if tgt>speed_q → ACCEL.
  - Else if tgt<speed_q → DECEL.
- **ACCEL:**
  - On tick with speed_q<tgt, pulse inc.
  - When speed_q==tgt → CRUISE.
  - When tgt<speed_q → DECEL.
- **DECEL:**
  - On tick with speed_q>tgt, pulse dec.
  - When speed_q==tgt: go to STOP_WAIT if speed_q==0 and a direction mismatch exists; else IDLE if tgt==0; else CRUISE.
  - When tgt>speed_q → ACCEL.
- **CRUISE:**
  - No pulses.
  - tgt>speed_q → ACCEL; tgt<speed_q → DECEL.
  - tgt==0 and speed_q==0 → IDLE.
- **STOP_WAIT:**
  - Dwell counter counts up from 0.
  - If the mismatch disappears (rev_req returns to the committed direction) → IDLE with the counter cleared.
  - When count==DWELL-1 → FLIP.
- **FLIP:**
  - Single cycle; dir_fwd toggles on exit.
  - Next state: IDLE. Acceleration in the new direction then follows through IDLE → ACCEL.
- **ESTOP:**
  - estop=1 in any state forces ESTOP on the next edge; estop has highest priority.
  - Pulse dec every cycle (prescaler ignored) while speed_q>0. dec drops when speed_q==0.
  - Exit to IDLE only when estop=0, go=0 and speed_q==0.
  - dir_fwd is frozen in ESTOP.
- **Invariants:**
  - inc and dec are never high in the same cycle.
  - inc is never high when speed_q==15; dec is never high when speed_q==0.
  - dir_fwd changes only in FLIP, and only when speed_q==0.
  - Pulses are registered outputs, asserted one cycle after the decision edge; STEP_DIV>=2 guarantees feedback settles before the next tick.
- **Simultaneous events:**
  - estop overrides everything.
  - A target change during ACCEL/DECEL is re-evaluated each cycle.
  - A rev_req toggle during DECEL toward 0 is absorbed by the tgt recomputation.

Test Plan:
1. Reset low for 3 cycles, then high with go=0 → inc=dec=0, dir_fwd=1, state=0, busy=0.
2. go=1, target_speed=5, rev_req=0, speed unit modelled → exactly 5 inc pulses spaced 4 cycles apart, then state=CRUISE and at_speed=1 with speed_q=5.
3. At speed 5, set rev_req=1 → 5 dec pulses, STOP_WAIT lasting 8 cycles, FLIP, dir_fwd=0, then 5 inc pulses back to speed 5.
4. At speed 7, assert estop → dec on 7 consecutive cycles, then speed_q=0 and state=ESTOP; deassert estop with go=1 → stays ESTOP; go=0 → IDLE.
5. Mid-ACCEL at speed 3 of a target of 10, pull reset low → inc=0 asynchronously, dir_fwd=1, state=IDLE; no pulse on release.
6. target_speed=15 with speed_q=15 held, and target_speed=0 with speed_q=0 → no inc at 15, no dec at 0, and never inc and dec together.
